// File: rtl/arb3_rr.sv
// Three-way round-robin arbiter with a bounded hold time. The grant is one-hot and registered.
// When the hold expires, the owner is forced to release and goes to the back of the priority order.
module arb3_rr #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t     state_q;
  logic [1:0] owner_q;
  logic [1:0] last_q;
  logic [7:0] hold_cnt_q;
  logic [2:0] gnt_q;
  logic       timeout_q;
  logic [1:0] owner_d;

  // Search order starts just after the previous owner, so that owner is considered last.
  always_comb begin
    owner_d = 2'd0;
    case (last_q)
      2'd0:    owner_d = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    owner_d = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: owner_d = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      last_q     <= 2'd2;
      hold_cnt_q <= 8'd0;
      gnt_q      <= 3'b000;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req != 3'b000) begin
            state_q    <= GRANT;
            owner_q    <= owner_d;
            gnt_q      <= 3'b001 << owner_d;
            hold_cnt_q <= 8'd1;
          end
        end
        default: begin
          // A normal release takes precedence over expiry on the same edge.
          if (!req[owner_q] || hold_cnt_q == MAX_HOLD_C) begin
            state_q    <= IDLE;
            last_q     <= owner_q;
            owner_q    <= 2'd0;
            gnt_q      <= 3'b000;
            hold_cnt_q <= 8'd0;
            timeout_q  <= req[owner_q];
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = owner_q;
  assign busy    = |gnt_q;
  assign timeout = timeout_q;

endmodule
